dm_access_ctrl: RTL and testbench

- Data-memory access stage directly downstream of DAG_top.
- Consumes the DAG's DM address (dg_dm_add) plus read/write strobes from the program sequencer.
- Posts writes into a small write buffer and serialises all accesses onto a single-outstanding req/ack memory port.
- Returns read data to the bus-connect data path and stalls the sequencer while a read is in flight.

---
 rtl/dm_access_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_access_ctrl.sv
// Data-memory access stage: posted-write buffer in front of a single-outstanding req/ack memory port.
// Optional read forwarding from the write buffer is enabled by defining DM_WBUF_FWD_EN.
module dm_access_ctrl #(
    parameter int unsigned ADD_W      = 16,
    parameter int unsigned DT_W       = 16,
    parameter int unsigned WBUF_DEPTH = 2,
    parameter int unsigned TMO_CYC    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADD_W-1:0] dg_dm_add,
    input  logic             ps_dm_rd_en,
    input  logic             ps_dm_wrt_en,
    input  logic [DT_W-1:0]  bc_dt,
    output logic             dm_ps_stall,
    output logic             dm_ps_err,
    output logic [DT_W-1:0]  dm_bc_dt,
    output logic             dm_bc_vld,
    output logic             dm_mem_req,
    output logic             dm_mem_wrt,
    output logic [ADD_W-1:0] dm_mem_add,
    output logic [DT_W-1:0]  dm_mem_wdt,
    input  logic             mem_dm_ack,
    input  logic [DT_W-1:0]  mem_dm_rdt
);

    localparam int unsigned PW = $clog2(WBUF_DEPTH);
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {IDLE, WR_BUS, RD_DRAIN, RD_BUS} state_e;

    state_e           state_q, state_d;
    logic [PW:0]      wptr_q, rptr_q, wptr_d, rptr_d;
    logic [ADD_W-1:0] badd_q [WBUF_DEPTH];
    logic [DT_W-1:0]  bdat_q [WBUF_DEPTH];
    logic [ADD_W-1:0] rd_add_q, rd_add_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             req_q, req_d, wrt_q, wrt_d;
    logic [ADD_W-1:0] madd_q, madd_d;
    logic [DT_W-1:0]  mwdt_q, mwdt_d;
    logic [DT_W-1:0]  bcdt_q, bcdt_d;
    logic             vld_q, vld_d, err_q, err_d;

    logic             empty, full, ack, tmo, pop, push, stall;
    logic             accept, rd_acc, rd_mem, rd_fwd, empty_after, byp;
    logic             hit;
    logic [DT_W-1:0]  hit_dt;
    logic [PW-1:0]    head_idx;

    assign empty       = (wptr_q == rptr_q);
    assign full        = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    assign ack         = req_q & mem_dm_ack;
    assign tmo         = req_q & ~mem_dm_ack & (tmo_q == TW'(TMO_CYC - 1));
    assign pop         = wrt_q & (ack | tmo);
    // A full buffer still takes a write in the cycle its head is retired.
    assign stall       = (state_q == RD_DRAIN) | (state_q == RD_BUS)
                       | (ps_dm_wrt_en & full & ~pop);
    assign accept      = (ps_dm_rd_en | ps_dm_wrt_en) & ~stall;
    assign push        = accept & ps_dm_wrt_en;
    assign rd_acc      = accept & ps_dm_rd_en & ~ps_dm_wrt_en;
    assign rd_fwd      = rd_acc & hit;
    assign rd_mem      = rd_acc & ~hit;
    assign wptr_d      = wptr_q + (PW+1)'(push);
    assign rptr_d      = rptr_q + (PW+1)'(pop);
    assign empty_after = (wptr_d == rptr_d);
    assign head_idx    = rptr_d[PW-1:0];
    assign byp         = push & (wptr_q[PW-1:0] == head_idx);

`ifdef DM_WBUF_FWD_EN
    logic [PW:0] cnt;
    assign cnt = wptr_q - rptr_q;

    // Scan oldest to newest so the newest matching entry wins.
    always_comb begin
        logic [PW-1:0] idx;
        hit    = 1'b0;
        hit_dt = '0;
        idx    = '0;
        for (int unsigned k = 0; k < WBUF_DEPTH; k++) begin
            idx = rptr_q[PW-1:0] + PW'(k);
            if (((PW+1)'(k) < cnt) && (badd_q[idx] == dg_dm_add)) begin
                hit    = 1'b1;
                hit_dt = bdat_q[idx];
            end
        end
    end
`else
    assign hit    = 1'b0;
    assign hit_dt = '0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        rd_add_d = rd_add_q;
        bcdt_d   = bcdt_q;
        vld_d    = 1'b0;
        err_d    = (push & ps_dm_rd_en) | tmo;
        tmo_d    = (req_q & ~mem_dm_ack & ~tmo) ? tmo_q + TW'(1) : '0;

        case (state_q)
            IDLE, WR_BUS: begin
                if (rd_mem) begin
                    rd_add_d = dg_dm_add;
                    state_d  = empty_after ? RD_BUS : RD_DRAIN;
                end else begin
                    state_d  = empty_after ? IDLE : WR_BUS;
                end
            end
            RD_DRAIN: begin
                if (empty_after) state_d = RD_BUS;
            end
            RD_BUS: begin
                if (ack | tmo) begin
                    state_d = IDLE;
                    bcdt_d  = ack ? mem_dm_rdt : '1;
                    vld_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rd_fwd) begin
            bcdt_d = hit_dt;
            vld_d  = 1'b1;
        end

        req_d  = (state_d != IDLE);
        wrt_d  = (state_d == WR_BUS) || (state_d == RD_DRAIN);
        madd_d = '0;
        mwdt_d = '0;
        if (wrt_d) begin
            madd_d = byp ? dg_dm_add : badd_q[head_idx];
            mwdt_d = byp ? bc_dt     : bdat_q[head_idx];
        end else if (state_d == RD_BUS) begin
            madd_d = rd_add_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wptr_q   <= '0;
            rptr_q   <= '0;
            rd_add_q <= '0;
            tmo_q    <= '0;
            req_q    <= 1'b0;
            wrt_q    <= 1'b0;
            madd_q   <= '0;
            mwdt_q   <= '0;
            bcdt_q   <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            rd_add_q <= rd_add_d;
            tmo_q    <= tmo_d;
            req_q    <= req_d;
            wrt_q    <= wrt_d;
            madd_q   <= madd_d;
            mwdt_q   <= mwdt_d;
            bcdt_q   <= bcdt_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    // Buffer storage needs no reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            badd_q[wptr_q[PW-1:0]] <= dg_dm_add;
            bdat_q[wptr_q[PW-1:0]] <= bc_dt;
        end
    end

    assign dm_ps_stall = stall;
    assign dm_ps_err   = err_q;
    assign dm_bc_dt    = bcdt_q;
    assign dm_bc_vld   = vld_q;
    assign dm_mem_req  = req_q;
    assign dm_mem_wrt  = wrt_q;
    assign dm_mem_add  = madd_q;
    assign dm_mem_wdt  = mwdt_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: per-cycle vector table plus hand sequences for
// forwarding/ordering, ack timeout and mid-transaction reset.
module tb_dm_access_ctrl;

    logic        clk, rst;
    logic [15:0] dg_dm_add, bc_dt, mem_dm_rdt;
    logic        ps_dm_rd_en, ps_dm_wrt_en, mem_dm_ack;
    logic        dm_ps_stall, dm_ps_err, dm_bc_vld, dm_mem_req, dm_mem_wrt;
    logic [15:0] dm_bc_dt, dm_mem_add, dm_mem_wdt;

    dm_access_ctrl dut (
        .clk(clk), .rst(rst),
        .dg_dm_add(dg_dm_add), .ps_dm_rd_en(ps_dm_rd_en), .ps_dm_wrt_en(ps_dm_wrt_en),
        .bc_dt(bc_dt), .dm_ps_stall(dm_ps_stall), .dm_ps_err(dm_ps_err),
        .dm_bc_dt(dm_bc_dt), .dm_bc_vld(dm_bc_vld), .dm_mem_req(dm_mem_req),
        .dm_mem_wrt(dm_mem_wrt), .dm_mem_add(dm_mem_add), .dm_mem_wdt(dm_mem_wdt),
        .mem_dm_ack(mem_dm_ack), .mem_dm_rdt(mem_dm_rdt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wrt;
        logic [15:0] add, dt;
        logic        ack;
        logic [15:0] rdt;
        logic        e_stall, e_req, e_mwrt;
        logic [15:0] e_madd, e_mwdt;
        logic        e_vld, e_err;
        logic [15:0] e_bcdt;
    } vec_t;

    localparam int NV = 15;
    vec_t tv [NV];

    int n_vec = 0;
    int n_bad = 0;

    logic        s_stall, s_req, s_mwrt, s_vld, s_err;
    logic [15:0] s_madd, s_mwdt, s_bcdt;

    function automatic vec_t v(input logic rd, input logic wrt, input logic [15:0] add,
                               input logic [15:0] dt, input logic ack, input logic [15:0] rdt,
                               input logic st, input logic rq, input logic mw,
                               input logic [15:0] ma, input logic [15:0] md,
                               input logic vl, input logic er, input logic [15:0] bd);
        vec_t r;
        r.rd = rd; r.wrt = wrt; r.add = add; r.dt = dt; r.ack = ack; r.rdt = rdt;
        r.e_stall = st; r.e_req = rq; r.e_mwrt = mw; r.e_madd = ma; r.e_mwdt = md;
        r.e_vld = vl; r.e_err = er; r.e_bcdt = bd;
        return r;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkn(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle();
        ps_dm_rd_en = 1'b0; ps_dm_wrt_en = 1'b0; dg_dm_add = 16'h0; bc_dt = 16'h0;
        mem_dm_ack = 1'b0; mem_dm_rdt = 16'h0;
    endtask

    // Called just after a negedge with inputs set; samples this cycle, then advances one clock.
    task automatic cyc();
        #1;
        s_stall = dm_ps_stall; s_req = dm_mem_req; s_mwrt = dm_mem_wrt; s_vld = dm_bc_vld;
        s_err = dm_ps_err; s_madd = dm_mem_add; s_mwdt = dm_mem_wdt; s_bcdt = dm_bc_dt;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        bit dropped;

        //       rd    wrt   add       dt        ack   rdt       stall req   mwrt  madd      mwdt      vld   err   bcdt
        tv[0]  = v(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        tv[1]  = v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, 1'b0, 16'h0000);
        tv[2]  = v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1234);
        tv[3]  = v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234);
        tv[4]  = v(1'b0, 1'b1, 16'h0010, 16'hAAAA, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234);
        tv[5]  = v(1'b0, 1'b1, 16'h0011, 16'hBBBB, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0010, 16'hAAAA, 1'b0, 1'b0, 16'h1234);
        tv[6]  = v(1'b0, 1'b1, 16'h0012, 16'hCCCC, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0010, 16'hAAAA, 1'b0, 1'b0, 16'h1234);
        tv[7]  = v(1'b0, 1'b1, 16'h0012, 16'hCCCC, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h0010, 16'hAAAA, 1'b0, 1'b0, 16'h1234);
        tv[8]  = v(1'b0, 1'b1, 16'h0012, 16'hCCCC, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0010, 16'hAAAA, 1'b0, 1'b0, 16'h1234);
        tv[9]  = v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0011, 16'hBBBB, 1'b0, 1'b0, 16'h1234);
        tv[10] = v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0012, 16'hCCCC, 1'b0, 1'b0, 16'h1234);
        tv[11] = v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234);
        tv[12] = v(1'b1, 1'b1, 16'h0030, 16'h7777, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234);
        tv[13] = v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0030, 16'h7777, 1'b0, 1'b1, 16'h1234);
        tv[14] = v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h1234);

        idle();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            ps_dm_rd_en = tv[i].rd; ps_dm_wrt_en = tv[i].wrt; dg_dm_add = tv[i].add;
            bc_dt = tv[i].dt; mem_dm_ack = tv[i].ack; mem_dm_rdt = tv[i].rdt;
            cyc();
            chk1 ($sformatf("v%0d stall", i), s_stall, tv[i].e_stall);
            chk1 ($sformatf("v%0d req", i),   s_req,   tv[i].e_req);
            chk1 ($sformatf("v%0d mwrt", i),  s_mwrt,  tv[i].e_mwrt);
            chk16($sformatf("v%0d madd", i),  s_madd,  tv[i].e_madd);
            chk16($sformatf("v%0d mwdt", i),  s_mwdt,  tv[i].e_mwdt);
            chk1 ($sformatf("v%0d vld", i),   s_vld,   tv[i].e_vld);
            chk1 ($sformatf("v%0d err", i),   s_err,   tv[i].e_err);
            chk16($sformatf("v%0d bcdt", i),  s_bcdt,  tv[i].e_bcdt);
        end

        // Write then read of the same address.
        idle(); ps_dm_wrt_en = 1'b1; dg_dm_add = 16'h0020; bc_dt = 16'h5555;
        cyc();
        chk1("fw wr stall", s_stall, 1'b0);
        idle(); ps_dm_rd_en = 1'b1; dg_dm_add = 16'h0020;
        cyc();
        chk1 ("fw rd stall", s_stall, 1'b0);
        chk1 ("fw wr req", s_req, 1'b1);
        chk1 ("fw wr mwrt", s_mwrt, 1'b1);
        chk16("fw wr madd", s_madd, 16'h0020);
`ifdef DM_WBUF_FWD_EN
        idle(); mem_dm_ack = 1'b1;
        cyc();
        chk1 ("fw vld", s_vld, 1'b1);
        chk16("fw bcdt", s_bcdt, 16'h5555);
        chk1 ("fw drain mwrt", s_mwrt, 1'b1);
        idle();
        cyc();
        chk1("fw no rd req", s_req, 1'b0);
        chk1("fw vld off", s_vld, 1'b0);
`else
        idle(); mem_dm_ack = 1'b1;
        cyc();
        chk1 ("drain stall", s_stall, 1'b1);
        chk1 ("drain mwrt", s_mwrt, 1'b1);
        chk16("drain mwdt", s_mwdt, 16'h5555);
        chk1 ("drain vld", s_vld, 1'b0);
        idle(); mem_dm_ack = 1'b1; mem_dm_rdt = 16'h5555;
        cyc();
        chk1 ("rd after wr req", s_req, 1'b1);
        chk1 ("rd after wr mwrt", s_mwrt, 1'b0);
        chk16("rd after wr madd", s_madd, 16'h0020);
        idle();
        cyc();
        chk1 ("rd after wr vld", s_vld, 1'b1);
        chk16("rd after wr bcdt", s_bcdt, 16'h5555);
        chk1 ("rd after wr req off", s_req, 1'b0);
`endif

        // Read that is never acknowledged.
        idle(); ps_dm_rd_en = 1'b1; dg_dm_add = 16'h0050;
        cyc();
        chk1("tmo accept stall", s_stall, 1'b0);
        idle();
        nreq = 0;
        dropped = 1'b0;
        for (int k = 0; k < 40 && !dropped; k++) begin
            cyc();
            if (s_req) nreq++;
            else dropped = 1'b1;
        end
        chkn ("tmo req cycles", nreq, 15);
        chk1 ("tmo err", s_err, 1'b1);
        chk1 ("tmo vld", s_vld, 1'b1);
        chk16("tmo bcdt", s_bcdt, 16'hFFFF);
        cyc();
        chk1("tmo err once", s_err, 1'b0);
        chk1("tmo vld once", s_vld, 1'b0);
        chk1("tmo idle stall", s_stall, 1'b0);
        chk1("tmo idle req", s_req, 1'b0);

        // Reset while a read waits behind two buffered writes.
        idle(); ps_dm_wrt_en = 1'b1; dg_dm_add = 16'h0060; bc_dt = 16'h1111;
        cyc();
        idle(); ps_dm_wrt_en = 1'b1; dg_dm_add = 16'h0061; bc_dt = 16'h2222;
        cyc();
        chk1("rst wr2 stall", s_stall, 1'b0);
        idle(); ps_dm_rd_en = 1'b1; dg_dm_add = 16'h0062;
        cyc();
        chk1("rst rd stall", s_stall, 1'b0);
        idle(); rst = 1'b1;
        cyc();
        chk1 ("pre-rst stall", s_stall, 1'b1);
        chk16("pre-rst madd", s_madd, 16'h0060);
        rst = 1'b0;
        idle();
        cyc();
        chk1 ("post-rst req", s_req, 1'b0);
        chk1 ("post-rst stall", s_stall, 1'b0);
        chk1 ("post-rst vld", s_vld, 1'b0);
        chk16("post-rst bcdt", s_bcdt, 16'h0000);
        idle(); ps_dm_rd_en = 1'b1; dg_dm_add = 16'h0070;
        cyc();
        chk1("post-rst rd stall", s_stall, 1'b0);
        idle(); mem_dm_ack = 1'b1; mem_dm_rdt = 16'hABCD;
        cyc();
        chk1 ("post-rst rd req", s_req, 1'b1);
        chk1 ("post-rst rd mwrt", s_mwrt, 1'b0);
        chk16("post-rst rd madd", s_madd, 16'h0070);
        idle();
        cyc();
        chk1 ("post-rst rd vld", s_vld, 1'b1);
        chk16("post-rst rd bcdt", s_bcdt, 16'hABCD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
